rx_bit_timer: RTL and testbench

- Timing controller for a serial receiver. It sequences a cycle counter and a bit counter, both of flex_counter style (count, clear, rollover).
- On a detected start bit it waits to the middle of the start bit and verifies it. It then issues one sample strobe per bit period to the external shift register, checks the stop bit, and flags frame completion or error.
- Sits between the start-bit detector and the receive shift register / data buffer.

---
 rtl/rx_bit_timer.sv | 151 +++++++++++++++
 tb/tb_rx_bit_timer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rx_bit_timer.sv
// Receive bit timer: verifies the start bit at its centre, then strobes
// once per bit period, checks the stop bit and flags done/error.
//
// Ports:
//   clk, n_rst          clock, async active-low reset
//   start_bit_detected  start edge seen by the detector (IDLE only)
//   serial_in           synchronized serial line
//   abort               synchronous abort back to IDLE
//   cycles_per_bit      clocks per bit (<2 treated as 2), latched at start
//   bits_per_frame      strobes per frame incl. stop (0 treated as 1)
//   sample_strobe       one-cycle pulse at each bit centre
//   frame_done          one-cycle pulse after the last strobe
//   frame_error         stop bit of the last frame was 0
//   busy                not idle
module rx_bit_timer #(
    parameter int CNT_BITS     = 4,
    parameter int BIT_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    start_bit_detected,
    input  logic                    serial_in,
    input  logic                    abort,
    input  logic [CNT_BITS-1:0]     cycles_per_bit,
    input  logic [BIT_CNT_BITS-1:0] bits_per_frame,
    output logic                    sample_strobe,
    output logic                    frame_done,
    output logic                    frame_error,
    output logic                    busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HALF = 2'd1;
    localparam logic [1:0] BITS = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]              state;
    logic [CNT_BITS-1:0]     cyc_cnt;
    logic [BIT_CNT_BITS-1:0] bit_cnt;
    logic [CNT_BITS-1:0]     cpb_q;
    logic [BIT_CNT_BITS-1:0] nbits_q;

    logic [CNT_BITS-1:0]     cpb_in;
    logic [BIT_CNT_BITS-1:0] nbits_in;
    logic [CNT_BITS-1:0]     half;
    logic [CNT_BITS-1:0]     cyc_bits_nxt;
    logic                    cyc_roll;
    logic                    half_hit;
    logic                    bit_last;

    always_comb begin
        cpb_in = cycles_per_bit;
        if (cycles_per_bit < CNT_BITS'(2)) begin
            cpb_in = CNT_BITS'(2);
        end
        nbits_in = bits_per_frame;
        if (bits_per_frame == '0) begin
            nbits_in = BIT_CNT_BITS'(1);
        end
    end

    assign half     = cpb_q >> 1;
    assign half_hit = (cyc_cnt == half - CNT_BITS'(1));

    // Bit-period counter runs 1..cpb; the edge on which it reaches
    // cpb is the bit centre.
    always_comb begin
        cyc_bits_nxt = cyc_cnt + CNT_BITS'(1);
        if (cyc_cnt == cpb_q) begin
            cyc_bits_nxt = CNT_BITS'(1);
        end
    end

    assign cyc_roll = (cyc_bits_nxt == cpb_q);
    assign bit_last = (bit_cnt == nbits_q - BIT_CNT_BITS'(1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= IDLE;
            cyc_cnt       <= '0;
            bit_cnt       <= '0;
            cpb_q         <= '0;
            nbits_q       <= '0;
            sample_strobe <= 1'b0;
            frame_done    <= 1'b0;
            frame_error   <= 1'b0;
            busy          <= 1'b0;
        end else begin
            sample_strobe <= 1'b0;
            frame_done    <= 1'b0;
            if (abort) begin
                state   <= IDLE;
                cyc_cnt <= '0;
                bit_cnt <= '0;
                busy    <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        busy <= 1'b0;
                        if (start_bit_detected) begin
                            state       <= HALF;
                            cpb_q       <= cpb_in;
                            nbits_q     <= nbits_in;
                            cyc_cnt     <= '0;
                            bit_cnt     <= '0;
                            frame_error <= 1'b0;
                            busy        <= 1'b1;
                        end
                    end
                    HALF: begin
                        if (half_hit) begin
                            cyc_cnt <= '0;
                            if (serial_in) begin
                                // False start: line back high mid-bit.
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state <= BITS;
                            end
                        end else begin
                            cyc_cnt <= cyc_cnt + CNT_BITS'(1);
                        end
                    end
                    BITS: begin
                        cyc_cnt <= cyc_bits_nxt;
                        if (cyc_roll) begin
                            sample_strobe <= 1'b1;
                            bit_cnt <= bit_cnt + BIT_CNT_BITS'(1);
                            if (bit_last) begin
                                frame_error <= ~serial_in;
                                state       <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        // busy stays high for this cycle and drops
                        // on the following IDLE edge.
                        frame_done <= 1'b1;
                        state      <= IDLE;
                        cyc_cnt    <= '0;
                        bit_cnt    <= '0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_bit_timer.sv
// Directed bench for rx_bit_timer: expected strobe and frame_done edges
// are queued at start and matched by a negedge monitor.
module tb_rx_bit_timer;

    logic       tb_clk;
    logic       n_rst;
    logic       start_bit_detected;
    logic       serial_in;
    logic       abort;
    logic [3:0] cycles_per_bit;
    logic [3:0] bits_per_frame;
    logic       sample_strobe;
    logic       frame_done;
    logic       frame_error;
    logic       busy;

    int checks;
    int passed;
    int fails;
    int cyc;
    int strobe_q[$];
    int done_q[$];

    rx_bit_timer #(.CNT_BITS(4), .BIT_CNT_BITS(4)) dut (
        .clk                (tb_clk),
        .n_rst              (n_rst),
        .start_bit_detected (start_bit_detected),
        .serial_in          (serial_in),
        .abort              (abort),
        .cycles_per_bit     (cycles_per_bit),
        .bits_per_frame     (bits_per_frame),
        .sample_strobe      (sample_strobe),
        .frame_done         (frame_done),
        .frame_error        (frame_error),
        .busy               (busy)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    initial cyc = 0;
    always @(posedge tb_clk) cyc <= cyc + 1;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Output that rose at posedge cyc is seen here at the next negedge.
    always @(negedge tb_clk) begin
        if (sample_strobe === 1'b1) begin
            if (strobe_q.size() == 0) begin
                check("strobe_unexpected", cyc, 0);
            end else begin
                check("strobe_edge", cyc, strobe_q.pop_front());
            end
        end
        if (frame_done === 1'b1) begin
            if (done_q.size() == 0) begin
                check("done_unexpected", cyc, 0);
            end else begin
                check("done_edge", cyc, done_q.pop_front());
            end
        end
    end

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge tb_clk);
    endtask

    // Called at a negedge; start is sampled at the next posedge (T0).
    task automatic start_frame(input int cpb, input int n,
                               input int nstr, input bit done_exp,
                               output int t0);
        int ce;
        int ne;
        int h;
        ce = (cpb < 2) ? 2 : cpb;
        ne = (n == 0) ? 1 : n;
        h  = ce / 2;
        cycles_per_bit     = 4'(cpb);
        bits_per_frame     = 4'(n);
        start_bit_detected = 1'b1;
        t0 = cyc + 1;
        for (int k = 1; k <= nstr; k++) begin
            strobe_q.push_back(t0 + h + k * ce);
        end
        if (done_exp) begin
            done_q.push_back(t0 + h + ne * ce + 1);
        end
        @(negedge tb_clk);
        start_bit_detected = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        int t1;
        checks = 0;
        passed = 0;
        fails  = 0;
        n_rst              = 1'b0;
        start_bit_detected = 1'b0;
        serial_in          = 1'b1;
        abort              = 1'b0;
        cycles_per_bit     = 4'd10;
        bits_per_frame     = 4'd9;

        repeat (2) @(negedge tb_clk);
        check("reset_outs",
              {sample_strobe, frame_done, frame_error, busy}, 0);
        n_rst = 1'b1;
        repeat (3) @(negedge tb_clk);
        check("idle_busy", busy, 0);

        // Normal frame, stop bit 1.
        serial_in = 1'b0;
        start_frame(10, 9, 9, 1'b1, t0);
        check("busy_after_t0", busy, 1);
        wait_until(t0 + 90);
        serial_in = 1'b1;
        wait_until(t0 + 96);
        check("ok_frame_error", frame_error, 0);
        check("busy_t0_96", busy, 1);
        wait_until(t0 + 97);
        check("busy_fall", busy, 0);

        // Stop bit 0.
        serial_in = 1'b0;
        start_frame(10, 9, 9, 1'b1, t0);
        wait_until(t0 + 96);
        check("err_set", frame_error, 1);
        wait_until(t0 + 100);
        check("err_hold", frame_error, 1);

        // False start, then restart one cycle later.
        serial_in = 1'b1;
        start_frame(10, 9, 0, 1'b0, t0);
        check("err_clear_on_start", frame_error, 0);
        wait_until(t0 + 5);
        check("false_start_idle", busy, 0);

        // Ignored start and input change, then abort after 3 strobes.
        serial_in = 1'b0;
        start_frame(10, 9, 3, 1'b0, t0);
        wait_until(t0 + 29);
        start_bit_detected = 1'b1;
        cycles_per_bit     = 4'd4;
        bits_per_frame     = 4'd2;
        @(negedge tb_clk);
        start_bit_detected = 1'b0;
        check("ignored_start_busy", busy, 1);
        wait_until(t0 + 37);
        abort = 1'b1;
        @(negedge tb_clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_err_kept", frame_error, 0);
        wait_until(t0 + 120);
        check("abort_quiet", busy, 0);
        check("abort_strobe_q", strobe_q.size(), 0);

        // Abort and start together in IDLE: abort wins.
        abort              = 1'b1;
        start_bit_detected = 1'b1;
        @(negedge tb_clk);
        abort              = 1'b0;
        start_bit_detected = 1'b0;
        check("abort_beats_start", busy, 0);

        // cpb=3, N=2, then back-to-back cpb=0 (as 2), N=3, bad stop.
        serial_in = 1'b0;
        start_frame(3, 2, 2, 1'b1, t0);
        wait_until(t0 + 5);
        serial_in = 1'b1;
        wait_until(t0 + 8);
        check("min_err", frame_error, 0);
        serial_in = 1'b0;
        start_frame(0, 3, 3, 1'b1, t1);
        check("b2b_busy", busy, 1);
        wait_until(t1 + 8);
        check("b2b_err", frame_error, 1);

        // Async reset while idle clears frame_error at once.
        wait_until(t1 + 10);
        @(posedge tb_clk);
        #2;
        n_rst = 1'b0;
        #1;
        check("async_rst_idle",
              {sample_strobe, frame_done, frame_error, busy}, 0);
        @(negedge tb_clk);
        n_rst = 1'b1;

        // Async reset mid-frame after 4 strobes.
        serial_in = 1'b0;
        start_frame(10, 9, 4, 1'b0, t0);
        wait_until(t0 + 47);
        check("mid_busy", busy, 1);
        #2;
        n_rst = 1'b0;
        #1;
        check("async_rst_mid",
              {sample_strobe, frame_done, frame_error, busy}, 0);
        @(negedge tb_clk);
        n_rst = 1'b1;
        wait_until(t0 + 150);
        check("post_rst_idle", busy, 0);
        check("strobe_q_empty", strobe_q.size(), 0);
        check("done_q_empty", done_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
